// File: rtl/controlador_display_multiplexado_if.sv
// Bus between the multiplexed display controller, its shared 7-segment decoder
// and the board pins. The controller uses the slave view.
interface controlador_display_multiplexado_if #(
  parameter int N_DIGITOS = 4
);
  logic                     habilita;
  logic                     carga;
  logic [4*N_DIGITOS-1:0]   valor_bcd;
  logic [3:0]               bin_dec;
  logic [0:6]               decimal_dec;
  logic [0:6]               segmentos;
  logic [N_DIGITOS-1:0]     anodos;
  logic                     quadro_fim;

  modport master (
    output habilita, carga, valor_bcd, decimal_dec,
    input  bin_dec, segmentos, anodos, quadro_fim
  );

  modport slave (
    input  habilita, carga, valor_bcd, decimal_dec,
    output bin_dec, segmentos, anodos, quadro_fim
  );
endinterface

// File: rtl/controlador_display_multiplexado.sv
// Multiplexed common-anode 7-segment controller: scans N_DIGITOS digits through one
// shared decoder, with guard gaps, leading-zero suppression and frame-aligned updates.
module controlador_display_multiplexado #(
  parameter int N_DIGITOS     = 4,
  parameter int DIV_REFRESH   = 50000,
  parameter int GUARDA        = 2,
  parameter int SUPRIME_ZEROS = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  controlador_display_multiplexado_if.slave      bus
);

  localparam int CNT_MAX = (DIV_REFRESH > GUARDA) ? DIV_REFRESH : GUARDA;
  localparam int PW      = $clog2(CNT_MAX);
  localparam int IW      = $clog2(N_DIGITOS);
  localparam int VW      = 4 * N_DIGITOS;

  localparam logic [PW-1:0] ULT_EXIBE = PW'(DIV_REFRESH - 1);
  localparam logic [PW-1:0] ULT_TROCA = PW'(GUARDA - 1);
  localparam logic [IW-1:0] ULT_IDX   = IW'(N_DIGITOS - 1);

  typedef enum logic [1:0] {OCIOSO, EXIBE, TROCA} estado_t;

  estado_t              state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [VW-1:0]        shadow_q, shadow_d;
  logic [VW-1:0]        frame_q, frame_d;
  logic                 pend_q, pend_d;
  logic [3:0]           bin_q, bin_d;
  logic [N_DIGITOS-1:0] anodos_q, anodos_d;
  logic                 apagado_q, apagado_d;
  logic                 quadro_q, quadro_d;
  logic                 fronteira;

  // Invalid codes are always dark; a zero digit is dark only when every more
  // significant digit is also zero, and digit 0 always shows.
  function automatic logic blank(input logic [VW-1:0] v, input logic [IW-1:0] i);
    logic zeros;
    zeros = 1'b1;
    for (int j = 0; j < N_DIGITOS; j++) begin
      if (j >= int'(i)) zeros = zeros & (v[4*j +: 4] == 4'd0);
    end
    return (v[4*int'(i) +: 4] > 4'd9) ||
           ((SUPRIME_ZEROS != 0) && (i != '0) && zeros);
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    presc_d   = presc_q;
    shadow_d  = bus.carga ? bus.valor_bcd : shadow_q;
    pend_d    = pend_q | bus.carga;
    frame_d   = frame_q;
    fronteira = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (bus.habilita) begin
          state_d   = EXIBE;
          idx_d     = '0;
          presc_d   = '0;
          fronteira = 1'b1;
        end
      end
      EXIBE: begin
        if (presc_q == ULT_EXIBE) begin
          state_d = TROCA;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      TROCA: begin
        if (presc_q == ULT_TROCA) begin
          state_d = EXIBE;
          presc_d = '0;
          if (idx_q == ULT_IDX) begin
            idx_d     = '0;
            fronteira = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = OCIOSO;
    endcase

    if (!bus.habilita) begin
      state_d   = OCIOSO;
      idx_d     = '0;
      presc_d   = '0;
      fronteira = 1'b0;
    end

    // A strobe landing on the boundary wins over the older shadow contents.
    if (fronteira && (pend_q || bus.carga)) begin
      frame_d = bus.carga ? bus.valor_bcd : shadow_q;
      pend_d  = 1'b0;
    end

    anodos_d  = '1;
    bin_d     = '0;
    apagado_d = 1'b1;
    if (state_d == EXIBE) begin
      anodos_d[idx_d] = 1'b0;
      bin_d           = frame_d[4*int'(idx_d) +: 4];
      apagado_d       = blank(frame_d, idx_d);
    end
    quadro_d = (state_d == TROCA) && (presc_d == ULT_TROCA) && (idx_d == ULT_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= OCIOSO;
      idx_q     <= '0;
      presc_q   <= '0;
      shadow_q  <= '0;
      frame_q   <= '0;
      pend_q    <= 1'b0;
      bin_q     <= '0;
      anodos_q  <= '1;
      apagado_q <= 1'b1;
      quadro_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_d;
      pend_q    <= pend_d;
      bin_q     <= bin_d;
      anodos_q  <= anodos_d;
      apagado_q <= apagado_d;
      quadro_q  <= quadro_d;
    end
  end

  assign bus.bin_dec    = bin_q;
  assign bus.anodos     = anodos_q;
  assign bus.quadro_fim = quadro_q;
  assign bus.segmentos  = apagado_q ? 7'b1111111 : bus.decimal_dec;

endmodule

// File: tb/tb_controlador_display_multiplexado.sv
// Directed bench: two controllers (zero suppression on / off) share stimulus; a
// behavioural 7-segment decoder closes the bin_dec -> decimal_dec loop.
module tb_controlador_display_multiplexado;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        habilita = 1'b0;
  logic        carga = 1'b0;
  logic [15:0] valor = 16'h0000;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  controlador_display_multiplexado_if #(.N_DIGITOS(4)) ifa ();
  controlador_display_multiplexado_if #(.N_DIGITOS(4)) ifb ();

  function automatic logic [0:6] dec7(input logic [3:0] b);
    case (b)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b0110000;
    endcase
  endfunction

  assign ifa.habilita    = habilita;
  assign ifa.carga       = carga;
  assign ifa.valor_bcd   = valor;
  assign ifa.decimal_dec = dec7(ifa.bin_dec);
  assign ifb.habilita    = habilita;
  assign ifb.carga       = carga;
  assign ifb.valor_bcd   = valor;
  assign ifb.decimal_dec = dec7(ifb.bin_dec);

  controlador_display_multiplexado #(
    .N_DIGITOS(4), .DIV_REFRESH(4), .GUARDA(2), .SUPRIME_ZEROS(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  controlador_display_multiplexado #(
    .N_DIGITOS(4), .DIV_REFRESH(4), .GUARDA(2), .SUPRIME_ZEROS(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Frame position p in 0..23: digit p/6 lit for p%6 < 4, guard otherwise.
  function automatic logic [3:0] exp_an(input int p);
    logic [3:0] a;
    a = 4'hF;
    if (p % 6 < 4) a[p / 6] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] exp_dig(input logic [15:0] v, input int p);
    return v[4*(p / 6) +: 4];
  endfunction

  function automatic logic [0:6] exp_seg(input logic [15:0] v, input int p, input bit sup);
    int d;
    int h;
    logic [3:0] dg;
    d = p / 6;
    h = 0;
    if (p % 6 >= 4) return 7'b1111111;
    for (int j = 0; j < 4; j++) if (v[4*j +: 4] != 4'd0) h = j;
    dg = v[4*d +: 4];
    if (dg > 4'd9 || (sup && d > 0 && d > h)) return 7'b1111111;
    return dec7(dg);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Park in OCIOSO, then enable with a coincident strobe; returns sampled at frame position 0.
  task automatic start(input logic [15:0] v);
    habilita = 1'b0;
    carga    = 1'b0;
    tick();
    valor    = v;
    carga    = 1'b1;
    habilita = 1'b1;
    tick();
    carga    = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifa.anodos !== 4'hF || ifa.bin_dec !== 4'h0 || ifa.segmentos !== 7'b1111111 ||
        ifa.quadro_fim !== 1'b0) begin
      errors++;
      $display("FAIL reset: anodos=%b bin=%h seg=%b qf=%b expected 1111 0 1111111 0",
               ifa.anodos, ifa.bin_dec, ifa.segmentos, ifa.quadro_fim);
    end
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (ifa.anodos !== 4'hF || ifa.segmentos !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_hold: anodos=%b seg=%b expected 1111 1111111",
               ifa.anodos, ifa.segmentos);
    end
  endtask

  task automatic test_scan;
    valor    = 16'h1234;
    carga    = 1'b1;
    habilita = 1'b1;
    tick();
    carga    = 1'b0;
    for (int k = 0; k < 48; k++) begin
      checks++;
      if (ifa.anodos !== exp_an(k % 24)) begin
        errors++;
        $display("FAIL scan_anodos k=%0d: got %b expected %b", k, ifa.anodos, exp_an(k % 24));
      end
      checks++;
      if (ifa.quadro_fim !== (k % 24 == 23)) begin
        errors++;
        $display("FAIL scan_quadro k=%0d: got %b expected %b", k, ifa.quadro_fim, (k % 24 == 23));
      end
      if (k % 6 < 4) begin
        checks++;
        if (ifa.bin_dec !== exp_dig(16'h1234, k % 24) ||
            ifa.segmentos !== dec7(exp_dig(16'h1234, k % 24))) begin
          errors++;
          $display("FAIL scan_digit k=%0d: bin=%h seg=%b expected bin=%h", k, ifa.bin_dec,
                   ifa.segmentos, exp_dig(16'h1234, k % 24));
        end
      end
      tick();
    end
  endtask

  task automatic test_blanking;
    logic [15:0] vals [3];
    vals[0] = 16'h0070;
    vals[1] = 16'h0000;
    vals[2] = 16'h00A5;
    for (int t = 0; t < 3; t++) begin
      start(vals[t]);
      for (int k = 0; k < 24; k++) begin
        checks++;
        if (ifa.anodos !== exp_an(k) || ifa.segmentos !== exp_seg(vals[t], k, 1'b1)) begin
          errors++;
          $display("FAIL blank_sup val=%h k=%0d: anodos=%b seg=%b expected %b %b", vals[t], k,
                   ifa.anodos, ifa.segmentos, exp_an(k), exp_seg(vals[t], k, 1'b1));
        end
        if (t == 0) begin
          checks++;
          if (ifb.segmentos !== exp_seg(vals[t], k, 1'b0)) begin
            errors++;
            $display("FAIL blank_nosup val=%h k=%0d: seg=%b expected %b", vals[t], k,
                     ifb.segmentos, exp_seg(vals[t], k, 1'b0));
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_no_tearing;
    logic [15:0] v;
    start(16'h1234);
    for (int k = 0; k < 48; k++) begin
      v = (k < 24) ? 16'h1234 : 16'h5678;
      if (k % 6 < 4) begin
        checks++;
        if (ifa.bin_dec !== exp_dig(v, k % 24) || ifa.anodos !== exp_an(k % 24)) begin
          errors++;
          $display("FAIL tearing k=%0d: bin=%h anodos=%b expected %h %b", k, ifa.bin_dec,
                   ifa.anodos, exp_dig(v, k % 24), exp_an(k % 24));
        end
      end
      if (k == 8) begin
        valor = 16'h5678;
        carga = 1'b1;
      end
      tick();
      carga = 1'b0;
    end
  endtask

  task automatic test_habilita;
    start(16'h1234);
    tick();
    tick();
    habilita = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (ifa.anodos !== 4'hF || ifa.segmentos !== 7'b1111111 || ifa.quadro_fim !== 1'b0) begin
        errors++;
        $display("FAIL disable_dark k=%0d: anodos=%b seg=%b qf=%b expected 1111 1111111 0",
                 k, ifa.anodos, ifa.segmentos, ifa.quadro_fim);
      end
    end
    habilita = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ifa.anodos !== exp_an(k) || (k < 4 && ifa.bin_dec !== 4'h4)) begin
        errors++;
        $display("FAIL reenable k=%0d: anodos=%b bin=%h expected %b 4", k, ifa.anodos,
                 ifa.bin_dec, exp_an(k));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_troca;
    start(16'h1234);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    #2;
    checks++;
    if (ifa.anodos !== 4'hF || ifa.bin_dec !== 4'h0 || ifa.segmentos !== 7'b1111111 ||
        ifa.quadro_fim !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: anodos=%b bin=%h seg=%b qf=%b expected 1111 0 1111111 0",
               ifa.anodos, ifa.bin_dec, ifa.segmentos, ifa.quadro_fim);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (ifa.anodos !== exp_an(k) || ifa.segmentos !== exp_seg(16'h0000, k, 1'b1)) begin
        errors++;
        $display("FAIL after_reset k=%0d: anodos=%b seg=%b expected %b %b", k, ifa.anodos,
                 ifa.segmentos, exp_an(k), exp_seg(16'h0000, k, 1'b1));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_no_tearing();
    test_habilita();
    test_reset_mid_troca();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
